// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// UART_RX_PARITY_EN adds the PARITY state for 8E1 framing.
package uart_pkg;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} rx_state_e;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_e;
`endif

    localparam logic IDLE_LEVEL = 1'b1;

    // Rounded clock divider for one oversample tick.
    function automatic int calc_div(input longint clk_hz, input longint baud, input longint os);
        return int'((clk_hz + (baud * os) / 2) / (baud * os));
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every DIV clocks, synchronously clearable.
module uart_baud_tick #(
    parameter int DIV = 54
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_deser.sv
// UART receiver: synchronizer, oversampled 8N1 deserializer, valid/ready output.
// UART_RX_PARITY_EN selects 8E1 framing with even-parity checking.
import uart_pkg::*;

module uart_rx_deser #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det
);
    localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    logic                 rx_meta_p0, rx_s, rx_s_p2;
    logic                 tick, fall;
    rx_state_e            state, state_n;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 div_clr, cnt_clr, cnt_inc, shift_en;
    logic                 byte_done, ferr_set, brk_set, brk_clr;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad, par_err;
`endif

    // Stage p0/p1: two-flop synchronizer; p2: edge-detect history.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_meta_p0 <= IDLE_LEVEL;
            rx_s       <= IDLE_LEVEL;
            rx_s_p2    <= IDLE_LEVEL;
        end else begin
            rx_meta_p0 <= uart_rx;
            rx_s       <= rx_meta_p0;
            rx_s_p2    <= rx_s;
        end
    end

    assign fall = rx_s_p2 & ~rx_s;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .clr  (div_clr),
        .tick (tick)
    );

    always_comb begin
        state_n   = state;
        div_clr   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        shift_en  = 1'b0;
        byte_done = 1'b0;
        ferr_set  = 1'b0;
        brk_set   = 1'b0;
        brk_clr   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err   = 1'b0;
`endif
        case (state)
            IDLE: if (fall) begin
                state_n = START;
                div_clr = 1'b1;
                cnt_clr = 1'b1;
            end
            START: if (tick) begin
                if (tick_cnt == TW'(OVERSAMPLE / 2 - 1)) begin
                    cnt_clr = 1'b1;
                    state_n = rx_s ? IDLE : DATA;
                end else cnt_inc = 1'b1;
            end
            DATA: if (tick) begin
                if (tick_cnt == TW'(OVERSAMPLE - 1)) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_cnt == BW'(DATA_BITS - 1))
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                end else cnt_inc = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick) begin
                if (tick_cnt == TW'(OVERSAMPLE - 1)) begin
                    cnt_clr  = 1'b1;
                    state_n  = STOP;
                    par_err  = (^shreg) != rx_s;
                    ferr_set = par_err;
                end else cnt_inc = 1'b1;
            end
`endif
            STOP: if (tick) begin
                if (tick_cnt == TW'(OVERSAMPLE - 1)) begin
                    cnt_clr = 1'b1;
                    if (rx_s) begin
                        state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                        byte_done = ~par_bad;
`else
                        byte_done = 1'b1;
`endif
                    end else begin
                        state_n  = WAIT_IDLE;
                        ferr_set = 1'b1;
                        brk_set  = (shreg == '0);
                    end
                end else cnt_inc = 1'b1;
            end
            // Any low sample restarts the idle-time count.
            WAIT_IDLE: if (tick) begin
                if (!rx_s) cnt_clr = 1'b1;
                else if (tick_cnt == TW'(OVERSAMPLE - 1)) begin
                    cnt_clr = 1'b1;
                    brk_clr = 1'b1;
                    state_n = IDLE;
                end else cnt_inc = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // Stage p3: FSM state, counters and shift register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            break_det <= 1'b0;
        end else begin
            state <= state_n;
            if (cnt_clr)      tick_cnt <= '0;
            else if (cnt_inc) tick_cnt <= tick_cnt + 1'b1;
            if (shift_en)
                bit_cnt <= (bit_cnt == BW'(DATA_BITS - 1)) ? '0 : bit_cnt + 1'b1;
            if (brk_set)      break_det <= 1'b1;
            else if (brk_clr) break_det <= 1'b0;
        end
        if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst || div_clr) par_bad <= 1'b0;
        else if (par_err)       par_bad <= 1'b1;
    end
`endif

    // Stage p4: output register with valid/ready handshake and overrun detection.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_set;
            overrun   <= 1'b0;
            if (byte_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else overrun <= 1'b1;
            end else if (rx_valid && rx_ready) rx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Scoreboard bench for uart_rx_deser: directed frames, queue of expected bytes, decoupled monitor.
`timescale 1ns/1ps
module tb_uart_rx_deser;
    localparam int BIT = 864;

    logic       clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, break_det;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int xfer_cnt = 0, ferr_cnt = 0, ovr_cnt = 0;
    int last_xfer_cyc = 0, start_cyc = 0;
    int x0, f0, o0;
    logic [7:0] exp_q[$];

    uart_rx_deser dut (
        .sys_clk   (clk),
        .sys_rst   (sys_rst),
        .uart_rx   (uart_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .break_det (break_det)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and counts error pulses.
    always @(negedge clk) begin
        if (!sys_rst) begin
            if (rx_valid && rx_ready) begin
                xfer_cnt++;
                last_xfer_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got 0x%0h with no byte expected", rx_data);
                end else check("rx_data", int'(rx_data), int'(exp_q.pop_front()));
            end
            if (frame_err) ferr_cnt++;
            if (overrun)   ovr_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_data(input logic [7:0] d);
        start_cyc = cyc;
        uart_rx = 1'b0;
        step(BIT);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            step(BIT);
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_data(d);
`ifdef UART_RX_PARITY_EN
        uart_rx = ^d;
        step(BIT);
`endif
        uart_rx = 1'b1;
        step(BIT);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_byte_par(input logic [7:0] d, input logic par);
        send_data(d);
        uart_rx = par;
        step(BIT);
        uart_rx = 1'b1;
        step(BIT);
    endtask
`endif

    task automatic snap();
        x0 = xfer_cnt;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
    endtask

    initial begin
        // Reset state
        step(5);
        check("rst_rx_valid", int'(rx_valid), 0);
        check("rst_rx_data", int'(rx_data), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_break_det", int'(break_det), 0);
        sys_rst = 1'b0;
        step(2 * BIT);

        // Single byte 0x55 with ready high
        snap();
        exp_q.push_back(8'h55);
        send_byte(8'h55);
        step(20);
        check("t1_xfers", xfer_cnt - x0, 1);
        check("t1_frame_err", ferr_cnt - f0, 0);
        check("t1_overrun", ovr_cnt - o0, 0);
        check("t1_valid_dropped", int'(rx_valid), 0);
        check("t1_latency_ok", int'(last_xfer_cyc - start_cyc >= 8150 && last_xfer_cyc - start_cyc <= 8700), 1);

        // Line held low from reset: one frame error, break, then recovery
        uart_rx = 1'b0;
        sys_rst = 1'b1;
        step(4);
        sys_rst = 1'b0;
        snap();
        step(12000);
        check("t2_frame_err_once", ferr_cnt - f0, 1);
        check("t2_no_valid", xfer_cnt - x0, 0);
        check("t2_rx_valid", int'(rx_valid), 0);
        check("t2_break_set", int'(break_det), 1);
        uart_rx = 1'b1;
        step(400);
        check("t2_break_held", int'(break_det), 1);
        step(800);
        check("t2_break_clear", int'(break_det), 0);
        snap();
        exp_q.push_back(8'hA3);
        send_byte(8'hA3);
        step(20);
        check("t2_a3_xfers", xfer_cnt - x0, 1);

        // Short low glitch on an idle line
        snap();
        uart_rx = 1'b0;
        step(200);
        uart_rx = 1'b1;
        step(2000);
        check("t3_no_valid", xfer_cnt - x0, 0);
        check("t3_no_frame_err", ferr_cnt - f0, 0);
        check("t3_rx_valid", int'(rx_valid), 0);

        // Overrun: second byte dropped while the first is held
        rx_ready = 1'b0;
        snap();
        exp_q.push_back(8'hA5);
        send_byte(8'hA5);
        send_byte(8'h3C);
        step(20);
        check("t4_valid_held", int'(rx_valid), 1);
        check("t4_data_held", int'(rx_data), 8'hA5);
        check("t4_overrun_once", ovr_cnt - o0, 1);
        check("t4_no_xfer_yet", xfer_cnt - x0, 0);
        rx_ready = 1'b1;
        step(10);
        check("t4_single_xfer", xfer_cnt - x0, 1);
        check("t4_valid_clear", int'(rx_valid), 0);

        // Reset during bit 4 of 0xF0, then a clean 0x0F
        snap();
        start_cyc = cyc;
        uart_rx = 1'b0;
        step(BIT);
        for (int i = 0; i < 4; i++) begin
            uart_rx = 1'b0;
            step(BIT);
        end
        uart_rx = 1'b1;
        step(BIT / 2);
        sys_rst = 1'b1;
        step(3);
        sys_rst = 1'b0;
        step(2 * BIT);
        exp_q.push_back(8'h0F);
        send_byte(8'h0F);
        step(20);
        check("t5_xfers", xfer_cnt - x0, 1);
        check("t5_no_frame_err", ferr_cnt - f0, 0);
        check("t5_rx_data", int'(rx_data), 8'h0F);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 needs parity bit 1
        snap();
        send_byte_par(8'h07, 1'b0);
        step(20);
        check("t6_parity_err", ferr_cnt - f0, 1);
        check("t6_parity_no_xfer", xfer_cnt - x0, 0);
        snap();
        exp_q.push_back(8'h07);
        send_byte_par(8'h07, 1'b1);
        step(20);
        check("t6_good_xfer", xfer_cnt - x0, 1);
        check("t6_good_no_err", ferr_cnt - f0, 0);
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
